w_ptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO, replacing the bare binary write counter. It holds the binary and Gray write pointers and synchronises the read-domain Gray pointer into `w_clk`. From these it produces registered full, almost-full and fill-level outputs plus a sticky overflow flag. It sits between the write port logic, the dual-port RAM write address, and the Gray-pointer crossing to the read domain.

---
 rtl/w_ptr_ctrl_pkg.sv | 22 ++
 rtl/w_ptr_ctrl_sync_nff.sv | 29 ++
 rtl/w_ptr_ctrl.sv | 96 +++++++++
 tb/tb_w_ptr_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_ptr_ctrl_pkg.sv
// Shared asynchronous-FIFO definitions: Gray-code helpers and synchroniser depth floor,
// common to the write-side and read-side pointer controllers.
package w_ptr_ctrl_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int CODE_W          = 32;

    // Callers zero-extend narrower pointers into CODE_W and truncate the result back.
    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/w_ptr_ctrl_sync_nff.sv
// Resettable multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_nff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/w_ptr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO: binary/Gray write
// pointers, read-pointer synchronisation, and registered full/almost-full/level/overflow.
module w_ptr_ctrl
    import w_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   r_gray_ptr,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  w_ovf_clr,
    output logic                  w_accept,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr_bin,
    output logic [ADDR_WIDTH:0]   w_gray_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_overflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    // Full means the pointers differ only in their top two Gray bits.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    if (SYNC_STAGES < MIN_SYNC_STAGES || ADDR_WIDTH < 1) begin : g_bad_params
        $error("w_ptr_ctrl: SYNC_STAGES must be >= 2 and ADDR_WIDTH >= 1");
    end

    logic [PTR_W-1:0] r_ptr_bin;
    logic [PTR_W-1:0] r_gray;
    logic             r_full;
    logic             r_afull;
    logic [PTR_W-1:0] r_level;
    logic             r_ovf;

    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_r_gray_sync;
    logic [PTR_W-1:0] w_r_bin_sync;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_afull_next;

    sync_nff #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_d     (r_gray_ptr),
        .o_q     (w_r_gray_sync)
    );

    assign w_accept     = w_en & ~r_full;
    assign w_ptr_next   = r_ptr_bin + PTR_W'(w_accept);
    assign w_gray_next  = PTR_W'(bin2gray(CODE_W'(w_ptr_next)));
    assign w_r_bin_sync = PTR_W'(gray2bin(CODE_W'(w_r_gray_sync)));
    assign w_level_next = w_ptr_next - w_r_bin_sync;
    assign w_full_next  = (w_gray_next == (w_r_gray_sync ^ FULL_MASK));
    assign w_afull_next = (w_level_next >= afull_thresh);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ptr_bin <= '0;
            r_gray    <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ptr_bin <= w_ptr_next;
            r_gray    <= w_gray_next;
            r_full    <= w_full_next;
            r_afull   <= w_afull_next;
            r_level   <= w_level_next;
            if (w_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_addr        = r_ptr_bin[ADDR_WIDTH-1:0];
    assign w_ptr_bin     = r_ptr_bin;
    assign w_gray_ptr    = r_gray;
    assign w_full        = r_full;
    assign w_almost_full = r_afull;
    assign w_level       = r_level;
    assign w_overflow    = r_ovf;

endmodule

// File: tb/tb_w_ptr_ctrl.sv
// Scoreboard bench for w_ptr_ctrl: an occupancy-count reference model queues expected
// post-edge outputs, and a monitor compares them one clock edge at a time.
module tb_w_ptr_ctrl;

    localparam int ADDR_WIDTH  = 3;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 8;
    localparam int PTR_MOD     = 16;

    logic       w_clk = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       w_ovf_clr = 1'b0;
    logic [3:0] r_gray_ptr = '0;
    logic [3:0] afull_thresh = '0;
    logic       w_accept;
    logic [2:0] w_addr;
    logic [3:0] w_ptr_bin;
    logic [3:0] w_gray_ptr;
    logic       w_full;
    logic       w_almost_full;
    logic [3:0] w_level;
    logic       w_overflow;

    w_ptr_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_en          (w_en),
        .r_gray_ptr    (r_gray_ptr),
        .afull_thresh  (afull_thresh),
        .w_ovf_clr     (w_ovf_clr),
        .w_accept      (w_accept),
        .w_addr        (w_addr),
        .w_ptr_bin     (w_ptr_bin),
        .w_gray_ptr    (w_gray_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        int ptr;
        int gray;
        int full;
        int afull;
        int level;
        int ovf;
        int acc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: unbounded write/read counts; the read count reaches the write
    // side through a SYNC_STAGES-deep delay line.
    int   wcnt;
    int   rcnt;
    int   mFull;
    int   mOvf;
    int   rSeenQ[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int toGray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic modelReset();
        wcnt  = 0;
        rcnt  = 0;
        mFull = 0;
        mOvf  = 0;
        rSeenQ.delete();
        for (int i = 0; i < SYNC_STAGES; i++) rSeenQ.push_back(0);
    endtask

    // Drives one cycle of inputs (caller is between edges), predicts the next edge.
    task automatic applyStimulus(input bit en, input bit clr, input int rReq);
        exp_t e;
        int   rNew;
        int   rSeen;
        int   level;
        rNew = rReq;
        if (rNew > wcnt) rNew = wcnt;
        if (rNew < rcnt) rNew = rcnt;
        rcnt       = rNew;
        w_en       = en;
        w_ovf_clr  = clr;
        r_gray_ptr = 4'(toGray(rcnt % PTR_MOD));

        rSeen = rSeenQ.pop_front();
        rSeenQ.push_back(rcnt);
        if (en && mFull == 0) wcnt++;
        if (en && mFull != 0) mOvf = 1;
        else if (clr) mOvf = 0;
        level   = wcnt - rSeen;
        mFull   = (level == DEPTH) ? 1 : 0;
        e.ptr   = wcnt % PTR_MOD;
        e.gray  = toGray(e.ptr);
        e.full  = mFull;
        e.afull = (level >= int'(afull_thresh)) ? 1 : 0;
        e.level = level;
        e.ovf   = mOvf;
        e.acc   = (en && mFull == 0) ? 1 : 0;
        expQ.push_back(e);
        @(posedge w_clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge w_clk);
        w_rst_n    = 1'b0;
        w_en       = 1'b0;
        w_ovf_clr  = 1'b0;
        r_gray_ptr = '0;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        modelReset();
    endtask

    // Monitor: every edge out of reset presents one output set to compare.
    initial begin
        int   prevGray;
        exp_t e;
        prevGray = 0;
        forever begin
            @(posedge w_clk);
            #1;
            if (!w_rst_n) begin
                prevGray = 0;
            end else begin
                checkOutput("gray_step", int'($countones(w_gray_ptr ^ 4'(prevGray)) <= 1), 1);
                prevGray = int'(w_gray_ptr);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("w_ptr_bin", int'(w_ptr_bin), e.ptr);
                    checkOutput("w_addr", int'(w_addr), e.ptr % DEPTH);
                    checkOutput("w_gray_ptr", int'(w_gray_ptr), e.gray);
                    checkOutput("w_full", int'(w_full), e.full);
                    checkOutput("w_almost_full", int'(w_almost_full), e.afull);
                    checkOutput("w_level", int'(w_level), e.level);
                    checkOutput("w_overflow", int'(w_overflow), e.ovf);
                    checkOutput("w_accept", int'(w_accept), e.acc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit wrapped;
        int prevPtr;
        modelReset();
        afull_thresh = 4'd9;
        doReset();

        // Fill from empty, then one write too many.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("fill_ptr", int'(w_ptr_bin), 8);
        checkOutput("fill_level", int'(w_level), 8);
        checkOutput("fill_full", int'(w_full), 1);
        checkOutput("fill_ovf", int'(w_overflow), 1);
        checkOutput("fill_accept", int'(w_accept), 0);

        // Read release reaches the flags SYNC_STAGES edges after it is sampled.
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("release_full_held", int'(w_full), 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("release_full", int'(w_full), 0);
        checkOutput("release_level", int'(w_level), 7);

        // Overflow set/clear race.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("ovf_cleared", int'(w_overflow), 0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("refill_full", int'(w_full), 1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("ovf_set_wins", int'(w_overflow), 1);
        checkOutput("ovf_ptr_hold", int'(w_ptr_bin), 9);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("ovf_lone_clr", int'(w_overflow), 0);

        // Wrap-around with the reader trailing by 3.
        doReset();
        wrapped = 1'b0;
        prevPtr = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, wcnt - 3);
            if (int'(w_ptr_bin) < prevPtr) wrapped = 1'b1;
            prevPtr = int'(w_ptr_bin);
        end
        checkOutput("wrap_seen", int'(wrapped), 1);

        // Almost-full at threshold 6.
        afull_thresh = 4'd6;
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0);
        checkOutput("afull_5", int'(w_almost_full), 0);
        applyStimulus(1'b1, 1'b0, 0);
        checkOutput("afull_6", int'(w_almost_full), 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("afull_hold", int'(w_almost_full), 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("afull_fall", int'(w_almost_full), 0);

        afull_thresh = 4'd0;
        doReset();
        for (int i = 0; i < 30; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, rcnt + int'($urandom_range(0, 1)));
        checkOutput("afull_thr0", int'(w_almost_full), 1);

        afull_thresh = 4'd9;
        doReset();
        for (int i = 0; i < 30; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'b0, rcnt + int'($urandom_range(0, 1)));
        checkOutput("afull_thr9", int'(w_almost_full), 0);

        // Randomised traffic.
        doReset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) afull_thresh = 4'($urandom_range(0, 10));
            applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
                          rcnt + int'($urandom_range(0, 2)));
        end

        // Asynchronous reset mid-operation at level 5.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0);
        #1;
        w_rst_n = 1'b0;
        w_en    = 1'b0;
        #1;
        checkOutput("async_reset", int'({w_ptr_bin, w_gray_ptr, w_addr, w_full, w_almost_full,
                                         w_level, w_overflow, w_accept}), 0);
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        modelReset();

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge w_clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
